// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Brief    : Synchronises, debounces and decodes one push-button line into
//            clean level, press/release pulses, long-hold level and
//            auto-repeat pulses for the clock's mode/time-setting logic.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1024,  // stable samples to accept a change (>= 2)
  parameter int HOLD_CYCLES     = 32768, // pressed cycles before a long press (>= 1)
  parameter int REPEAT_CYCLES   = 8192   // auto-repeat period while held (>= 2)
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Button,
  input  logic i_Repeat_En,
  output logic o_Level,
  output logic o_Press,
  output logic o_Release,
  output logic o_Long,
  output logic o_Repeat
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int c_HR_W   = $clog2(c_HR_MAX + 1);

  // The debounce counter toggles the level on the edge where it would reach
  // DEBOUNCE_CYCLES, so the last value it ever holds is DEBOUNCE_CYCLES-1.
  localparam logic [c_DEB_W-1:0] c_DEB_LAST  = c_DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_DEB_W-1:0] c_DEB_ONE   = c_DEB_W'(1);

  // The hold counter is loaded with 1 on the press edge, so seeing
  // HOLD_CYCLES in PRESSED means the press is exactly HOLD_CYCLES old on
  // the following edge.
  localparam logic [c_HR_W-1:0]  c_HOLD_LAST = c_HR_W'(HOLD_CYCLES);
  localparam logic [c_HR_W-1:0]  c_REP_LAST  = c_HR_W'(REPEAT_CYCLES - 1);
  localparam logic [c_HR_W-1:0]  c_HR_ONE    = c_HR_W'(1);

  localparam logic [1:0] c_RELEASED = 2'd0;
  localparam logic [1:0] c_PRESSED  = 2'd1;
  localparam logic [1:0] c_HELD     = 2'd2;

  // --------------------------------------------------------------------------
  // Signals
  // --------------------------------------------------------------------------
  logic               sync1_q;
  logic               sync2_q;
  logic [c_DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic               level_q,   level_d;
  logic               press_q,   press_d;
  logic               release_q, release_d;
  logic [1:0]         state_q,   state_d;
  logic [c_HR_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               repeat_q,  repeat_d;

  // --------------------------------------------------------------------------
  // Front end: two-flop synchroniser plus debounce/event registers
  // --------------------------------------------------------------------------

  // Synchronise the raw line and register the debounced level and its edges.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= i_Button;
      sync2_q   <= sync1_q;
      deb_cnt_q <= deb_cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Count consecutive disagreeing samples; accept the new level once the run
  // is DEBOUNCE_CYCLES long, and flag which direction it moved.
  always_comb begin
    deb_cnt_d = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != level_q) begin
      if (deb_cnt_q == c_DEB_LAST) begin
        level_d   = ~level_q;
        press_d   = ~level_q;
        release_d = level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + c_DEB_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Hold / auto-repeat FSM
  // --------------------------------------------------------------------------

  // State register for the FSM, its shared counter and the repeat pulse.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= c_RELEASED;
      hold_cnt_q <= '0;
      repeat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      repeat_q   <= repeat_d;
    end
  end

  // Next-state logic; a release on this edge overrides any hold or repeat
  // decision so no repeat pulse can coincide with or follow o_Release.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    repeat_d   = 1'b0;
    if (release_d) begin
      state_d    = c_RELEASED;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        c_RELEASED: begin
          if (press_d) begin
            state_d    = c_PRESSED;
            hold_cnt_d = c_HR_ONE;
          end else begin
            hold_cnt_d = '0;
          end
        end
        c_PRESSED: begin
          if (hold_cnt_q == c_HOLD_LAST) begin
            state_d    = c_HELD;
            hold_cnt_d = '0;
            repeat_d   = i_Repeat_En;
          end else begin
            hold_cnt_d = hold_cnt_q + c_HR_ONE;
          end
        end
        c_HELD: begin
          // Counter free-runs regardless of the enable so re-enabling
          // resumes on the normal cadence without a catch-up pulse.
          if (hold_cnt_q == c_REP_LAST) begin
            hold_cnt_d = '0;
            repeat_d   = i_Repeat_En;
          end else begin
            hold_cnt_d = hold_cnt_q + c_HR_ONE;
          end
        end
        default: begin
          state_d    = c_RELEASED;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  // Long-hold level is a pure decode of the registered state.
  always_comb begin
    o_Long = (state_q == c_HELD);
  end

  assign o_Level   = level_q;
  assign o_Press   = press_q;
  assign o_Release = release_q;
  assign o_Repeat  = repeat_q;

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_conditioner
// Brief    : Scoreboard bench for button_conditioner. A timestamp-based
//            reference model predicts press/release/repeat events and the
//            level/long outputs; a monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

  localparam int DEB  = 16;
  localparam int HOLD = 64;
  localparam int REP  = 32;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_REPEAT  = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic i_Reset;
  logic i_Button;
  logic i_Repeat_En;
  logic o_Level;
  logic o_Press;
  logic o_Release;
  logic o_Long;
  logic o_Repeat;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  ev_t  exp_q[$];

  // reference model state
  bit   m_s1 = 1'b0;
  bit   m_s2 = 1'b0;
  bit   m_level = 1'b0;
  bit   m_long = 1'b0;
  bit   m_exp_zero = 1'b0;
  int   m_run_start = -1;
  int   m_press_cyc = -1;

  // monitor observations used by directed checks
  int   mon_press_cnt   = 0;
  int   mon_release_cnt = 0;
  int   mon_press_cyc   = 0;
  int   mon_release_cyc = 0;
  int   mon_rep_win     = 0;
  int   mon_rep_total   = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .i_Clock     (clk),
    .i_Reset     (i_Reset),
    .i_Button    (i_Button),
    .i_Repeat_En (i_Repeat_En),
    .o_Level     (o_Level),
    .o_Press     (o_Press),
    .o_Release   (o_Release),
    .o_Long      (o_Long),
    .o_Repeat    (o_Repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: evaluated once per rising edge from the sampled inputs.
  // The level follows the raw line seen two samples late once that delayed
  // value has disagreed with the level for DEB consecutive samples; hold and
  // repeat timing is arithmetic on the age of the current press.
  // --------------------------------------------------------------------------
  task automatic push_ev(input int kind);
    exp_q.push_back('{kind, cyc});
  endtask

  task automatic model_step();
    bit s;
    int k;
    cyc++;
    if (i_Reset) begin
      m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_long = 1'b0;
      m_run_start = -1; m_press_cyc = -1; m_exp_zero = 1'b1;
      return;
    end
    m_exp_zero = 1'b0;
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = i_Button;
    if (s != m_level) begin
      if (m_run_start < 0) m_run_start = cyc;
      if (cyc - m_run_start + 1 >= DEB) begin
        m_level = s;
        m_run_start = -1;
        if (m_level) begin
          m_press_cyc = cyc;
          push_ev(EV_PRESS);
        end else begin
          m_press_cyc = -1;
          push_ev(EV_RELEASE);
        end
      end
    end else begin
      m_run_start = -1;
    end
    if (m_level && m_press_cyc != cyc) begin
      k = cyc - m_press_cyc;
      if (k >= HOLD && ((k - HOLD) % REP) == 0 && i_Repeat_En) push_ev(EV_REPEAT);
    end
    m_long = m_level && (cyc - m_press_cyc >= HOLD);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // --------------------------------------------------------------------------
  // Monitor: samples on the falling edge, pops expected events as the DUT
  // presents pulses, and flags any expected event the DUT did not produce.
  // --------------------------------------------------------------------------
  task automatic check_ev(input int kind, input string nm);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected pulse at cycle %0d, no event expected", nm, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                 nm, kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (m_exp_zero) begin
        n_tests++;
        if ({o_Level, o_Press, o_Release, o_Long, o_Repeat} !== 5'b0) begin
          n_fail++;
          $display("FAIL reset_outputs: cycle %0d got %b, expected 00000", cyc,
                   {o_Level, o_Press, o_Release, o_Long, o_Repeat});
        end
      end
      n_tests++;
      if (o_Level !== m_level) begin
        n_fail++;
        $display("FAIL level: cycle %0d got %b, expected %b", cyc, o_Level, m_level);
      end
      n_tests++;
      if (o_Long !== m_long) begin
        n_fail++;
        $display("FAIL long: cycle %0d got %b, expected %b", cyc, o_Long, m_long);
      end
      if (o_Press === 1'b1) begin
        check_ev(EV_PRESS, "press");
        mon_press_cnt++;
        mon_press_cyc = cyc;
        mon_rep_win = 0;
      end
      if (o_Release === 1'b1) begin
        check_ev(EV_RELEASE, "release");
        mon_release_cnt++;
        mon_release_cyc = cyc;
      end
      if (o_Repeat === 1'b1) begin
        check_ev(EV_REPEAT, "repeat");
        mon_rep_total++;
        if (cyc - mon_press_cyc <= 200) mon_rep_win++;
      end
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL missed_event: kind %0d expected at cycle %0d, not seen by cycle %0d",
                 e.kind, e.cyc, cyc);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic chk(input string nm, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  task automatic hold(input bit b, input int n);
    i_Button = b;
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) until the monitor has counted a new press or release.
  task automatic wait_pulse(input bit rel, input string nm);
    int  start;
    bit  seen;
    start = rel ? mon_release_cnt : mon_press_cnt;
    seen  = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      #1;
      if ((rel ? mon_release_cnt : mon_press_cnt) != start) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: no pulse within 60 cycles", nm);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int rst_end, c0, rb, pc;

    // Reset with the button held: fresh press 18 cycles after release.
    i_Reset = 1'b1; i_Button = 1'b1; i_Repeat_En = 1'b1;
    repeat (3) @(negedge clk);
    i_Reset = 1'b0;
    rst_end = cyc;
    wait_pulse(1'b0, "reset_press_wait");
    chk("reset_press_latency", mon_press_cyc - rst_end, 18);

    // Long press with repeat: 5 repeats within 200 cycles of the press.
    repeat (200) @(negedge clk);
    #1;
    chk("repeat_count_200", mon_rep_win, 5);
    hold(1'b0, 40);

    // Clean press / release.
    i_Button = 1'b1;
    c0 = cyc;
    wait_pulse(1'b0, "clean_press_wait");
    chk("clean_press_latency", mon_press_cyc - c0, 18);
    repeat (c0 + 100 - cyc) @(negedge clk);
    i_Button = 1'b0;
    wait_pulse(1'b1, "clean_release_wait");
    chk("clean_release_latency", mon_release_cyc - (c0 + 100), 18);
    hold(1'b0, 30);

    // Bounce, then steady high: exactly one press after the final rise.
    pc = mon_press_cnt;
    hold(1'b1, 5); hold(1'b0, 3); hold(1'b1, 2); hold(1'b0, 1);
    i_Button = 1'b1;
    c0 = cyc;
    wait_pulse(1'b0, "bounce_press_wait");
    chk("bounce_press_latency", mon_press_cyc - c0, 18);
    hold(1'b1, 30);
    chk("bounce_single_press", mon_press_cnt - pc, 1);
    hold(1'b0, 40);

    // Glitch of 15 samples is rejected; 16 samples is just accepted.
    pc = mon_press_cnt;
    hold(1'b1, 15); hold(1'b0, 40);
    chk("glitch15_no_press", mon_press_cnt - pc, 0);
    hold(1'b1, 16); hold(1'b0, 40);
    chk("run16_press", mon_press_cnt - pc, 1);

    // Repeat gating while held.
    i_Button = 1'b1;
    wait_pulse(1'b0, "gate_press_wait");
    repeat (69) @(negedge clk);
    i_Repeat_En = 1'b0;
    #1;
    rb = mon_rep_total;
    repeat (40) @(negedge clk);
    i_Repeat_En = 1'b1;
    #1;
    chk("gate_no_repeat", mon_rep_total - rb, 0);
    chk("gate_long_held", int'(o_Long), 1);
    repeat (40) @(negedge clk);
    #1;
    chk("gate_resume", mon_rep_total - rb, 1);
    hold(1'b0, 40);

    // Release during repeat at press+150.
    i_Button = 1'b1;
    wait_pulse(1'b0, "rel_press_wait");
    repeat (150) @(negedge clk);
    i_Button = 1'b0;
    hold(1'b0, 60);
    chk("rel_latency", mon_release_cyc - mon_press_cyc, 168);
    chk("rel_repeat_count", mon_rep_win, 4);

    // Reset mid-hold, then the still-held button becomes a fresh press.
    i_Button = 1'b1;
    wait_pulse(1'b0, "midrst_press_wait");
    repeat (100) @(negedge clk);
    i_Reset = 1'b1;
    @(negedge clk);
    i_Reset = 1'b0;
    #1;
    chk("midrst_outputs", int'({o_Level, o_Press, o_Release, o_Long, o_Repeat}), 0);
    hold(1'b1, 40);
    hold(1'b0, 40);

    // Randomised segments against the model.
    for (int i = 0; i < 60; i++) begin
      int len;
      bit v;
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) len = int'($urandom_range(1, 20));
      else                           len = int'($urandom_range(20, 160));
      i_Repeat_En = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 29) == 0) begin
        i_Reset = 1'b1;
        repeat (int'($urandom_range(1, 3))) @(negedge clk);
        i_Reset = 1'b0;
      end
      hold(v, len);
    end

    hold(1'b0, 60);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
